neopixel_decoder: RTL and testbench
===================================

Name: neopixel_decoder

Overview:
- Receive-side counterpart of the neopixel driver. Samples a WS2812-style single-wire stream and measures high-pulse widths to recover bits.
- Assembles bits into 24-bit pixel words and reports each pixel and each end-of-frame (reset gap) to the control side.
- Used for loopback self-test of neopixel_drive and for bench checking of driver timing, all in the neopixel_clock domain.

Parameters:
- C_FREQ_HZ, 125000000: neopixel_clock frequency.
- C_PIXELS, 12: maximum pixels accepted per frame (1..255).
- C_BIT_THRESH_NS, 600: high width at or above this decodes as 1; below it decodes as 0.
- C_MIN_HIGH_NS, 150: high pulses shorter than this are glitches.
- C_RESET_NS, 50000: low time marking end of frame.
- Cycle counts are floor(C_FREQ_HZ/1000 * NS / 1000000), computed in 64-bit elaboration arithmetic. Defaults give T_BIT=75, T_MIN=18, T_RST=6250.

Ports:
- neopixel_clock  in  1  sole clock.
- neopixel_reset_n  in  1  asynchronous active-low reset.
- neopixel_in  in  1  asynchronous serial input.
- pixel_valid  out  1  one-cycle strobe; pixel_index and pixel_data are valid.
- pixel_index  out  8  pixel position in the frame, 0-based.
- pixel_data  out  24  pixel in wire order; the first received bit is bit 23 (G7..G0,R7..R0,B7..B0).
- frame_done  out  1  one-cycle strobe at the end of frame.
- frame_pixels  out  9  pixel words received in the last frame, including overflow (saturates at 511).
- frame_error  out  3  [0] glitch, [1] partial pixel, [2] overflow/stuck-high. Latched with frame_done.
- busy  out  1  high from the first accepted rising edge until frame_done.

Behaviour:
- Reset: all outputs 0, bit and pixel counters 0, state SYNC. Reset is asynchronous. Reset mid-frame discards all partial data with no strobes.
- Input path: 2-FF synchronizer, then an edge detector on the synchronized value (s). Edge detection latency is 3 cycles from the pin; all widths are measured on s.
- States:
  - SYNC: count consecutive low cycles. Any high clears the count. When the count reaches T_RST, go to IDLE without strobing. This prevents decoding a frame joined mid-stream.
  - IDLE: wait for s rising, then go to HIGH with hcnt=1 and busy=1.
  - HIGH: hcnt increments per high cycle (saturating).
    - If hcnt reaches T_RST: stuck-high. Set err[2], discard partial bits, go to SYNC. Emit frame_done after the next valid T_RST low period.
    - On s falling:
      - hcnt<T_MIN: set err[0], bit discarded.
      - Otherwise: bit = (hcnt>=T_BIT), shifted into sreg LSB-first (wire-MSB ends at bit 23), bitcnt++.
      - Then go to LOW with lcnt=1.
  - LOW: lcnt increments.
    - s rising before T_RST: go to HIGH (hcnt=1).
    - lcnt==T_RST: end of frame. Go to IDLE.
- Pixel completion: on the cycle after the falling edge that makes bitcnt=24:
  - If pcnt<C_PIXELS: pulse pixel_valid with pixel_index=pcnt and pixel_data=sreg.
  - Otherwise: set err[2] and suppress the strobe.
  - Then pcnt++ (saturating at 511) and bitcnt=0.
  - pixel_data and pixel_index hold until the next strobe.
- End of frame: on the cycle lcnt reaches T_RST:
  - frame_done=1 for one cycle.
  - frame_pixels=pcnt.
  - frame_error = accumulated err, with [1] set if bitcnt!=0.
  - busy=0. pcnt, bitcnt and err are cleared for the next frame.
  - frame_pixels and frame_error hold until the next frame_done.
- Simultaneous events: a pixel strobe and frame_done never coincide, since frame_done needs T_RST low cycles after the last fall. A frame of only glitches gives frame_done with frame_pixels=0 and err[0]=1.
- Boundaries: hcnt==T_BIT exactly decodes 1. hcnt==T_MIN-1 is a glitch. A low time of T_RST-1 cycles continues the frame.

Test Plan:
- Idle line for 6250 cycles after reset, then 24 bits of 0xA5_3C_F0 (1: 100 high/56 low; 0: 50 high/106 low), then 7000 low cycles. Expected: one pixel_valid with index 0 and data 0xA53CF0; frame_done with frame_pixels=1 and frame_error=0.
- 12 pixels (data = index*0x010101), then reset gap. Expected: 12 strobes in order, frame_pixels=12, no errors. Next frame restarts at index 0.
- 14 pixels with C_PIXELS=12. Expected: 12 strobes only, frame_pixels=14, frame_error=3'b100.
- Threshold sweep: high widths 74, 75, 18 and 17 cycles. Expected: bits 0, 1, 0, then glitch with no bit, giving err[0]=1 and err[1]=1 at frame_done.
- 30 bits then reset gap. Expected: 1 strobe, frame_error[1]=1, frame_pixels=1.
- Pulses applied before the initial 6250-cycle low, then reset_n asserted mid-pixel. Expected: no strobes, all outputs 0 immediately, and SYNC is required again before decoding.

Source files
------------

// File: rtl/neopixel_decoder_if.sv
// neopixel_decoder_if: pixel and frame report bundle from neopixel_decoder to its consumer.
interface neopixel_decoder_if;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic [23:0] pixel_data;
  logic        frame_done;
  logic [8:0]  frame_pixels;
  logic [2:0]  frame_error;
  logic        busy;
  modport master (output pixel_valid, pixel_index, pixel_data, frame_done, frame_pixels, frame_error, busy);
  modport slave  (input  pixel_valid, pixel_index, pixel_data, frame_done, frame_pixels, frame_error, busy);
endinterface

// File: rtl/neopixel_decoder.sv
// neopixel_decoder: measures WS2812 high-pulse widths on a synchronized input and
// reports recovered 24-bit pixel words and end-of-frame summaries.
module neopixel_decoder #(
  parameter int unsigned C_FREQ_HZ       = 125000000,
  parameter int unsigned C_PIXELS        = 12,
  parameter int unsigned C_BIT_THRESH_NS = 600,
  parameter int unsigned C_MIN_HIGH_NS   = 150,
  parameter int unsigned C_RESET_NS      = 50000
) (
  input  logic               neopixel_clock,
  input  logic               neopixel_reset_n,
  input  logic               neopixel_in,
  neopixel_decoder_if.master bus
);
  localparam longint unsigned T_BIT = 64'(C_FREQ_HZ) / 64'd1000 * 64'(C_BIT_THRESH_NS) / 64'd1000000;
  localparam longint unsigned T_MIN = 64'(C_FREQ_HZ) / 64'd1000 * 64'(C_MIN_HIGH_NS) / 64'd1000000;
  localparam longint unsigned T_RST = 64'(C_FREQ_HZ) / 64'd1000 * 64'(C_RESET_NS) / 64'd1000000;
  localparam int CW = $clog2(T_RST + 1);
  localparam logic [CW-1:0] L_BIT  = CW'(T_BIT);
  localparam logic [CW-1:0] L_MIN  = CW'(T_MIN);
  localparam logic [CW-1:0] L_RST  = CW'(T_RST);
  localparam logic [CW-1:0] L_RST1 = CW'(T_RST - 1);
  localparam logic [8:0]    L_PIX  = 9'(C_PIXELS);
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
  state_t         r_state, w_state;
  logic [2:0]     r_sync;
  logic [CW-1:0]  r_hcnt, w_hcnt, r_lcnt, w_lcnt;
  logic [4:0]     r_bitcnt, w_bitcnt;
  logic [8:0]     r_pcnt, w_pcnt;
  logic [23:0]    r_sreg, w_sreg;
  logic [2:0]     r_err, w_err;
  logic           r_busy, w_busy;
  logic           r_pixel_valid, w_pixel_valid;
  logic [7:0]     r_pixel_index, w_pixel_index;
  logic [23:0]    r_pixel_data, w_pixel_data;
  logic           r_frame_done, w_frame_done;
  logic [8:0]     r_frame_pixels, w_frame_pixels;
  logic [2:0]     r_frame_error, w_frame_error;
  logic           w_s, w_rise, w_fall, w_eof;
  assign w_s    = r_sync[1];
  assign w_rise = w_s & ~r_sync[2];
  assign w_fall = ~w_s & r_sync[2];
  always_comb begin
    w_state        = r_state;
    w_hcnt         = r_hcnt;
    w_lcnt         = r_lcnt;
    w_bitcnt       = r_bitcnt;
    w_pcnt         = r_pcnt;
    w_sreg         = r_sreg;
    w_err          = r_err;
    w_busy         = r_busy;
    w_pixel_valid  = 1'b0;
    w_pixel_index  = r_pixel_index;
    w_pixel_data   = r_pixel_data;
    w_frame_done   = 1'b0;
    w_frame_pixels = r_frame_pixels;
    w_frame_error  = r_frame_error;
    w_eof          = 1'b0;
    // a full word is retired the cycle after its last fall; the next fall is at least two cycles away
    if (r_bitcnt == 5'd24) begin
      w_pixel_valid = r_pcnt < L_PIX;
      w_pixel_index = w_pixel_valid ? r_pcnt[7:0] : r_pixel_index;
      w_pixel_data  = w_pixel_valid ? r_sreg : r_pixel_data;
      w_err[2]      = r_err[2] | ~w_pixel_valid;
      w_pcnt        = r_pcnt + {8'd0, r_pcnt != 9'h1ff};
      w_bitcnt      = 5'd0;
    end
    case (r_state)
      SYNC:
        if (w_s) w_lcnt = '0;
        else if (r_lcnt == L_RST1) begin
          w_state = IDLE;
          w_eof   = r_busy;
        end else w_lcnt = r_lcnt + CW'(1);
      IDLE:
        if (w_rise) begin
          w_state = HIGH;
          w_hcnt  = CW'(1);
          w_busy  = 1'b1;
        end
      HIGH:
        if (w_fall) begin
          if (r_hcnt < L_MIN) w_err[0] = 1'b1;
          else begin
            w_sreg   = {r_sreg[22:0], r_hcnt >= L_BIT};
            w_bitcnt = r_bitcnt + 5'd1;
          end
          w_state = LOW;
          w_lcnt  = CW'(1);
        end else if (r_hcnt == L_RST) begin
          w_err[2] = 1'b1;
          w_bitcnt = 5'd0;
          w_state  = SYNC;
          w_lcnt   = '0;
        end else w_hcnt = r_hcnt + CW'(1);
      LOW:
        if (w_rise) begin
          w_state = HIGH;
          w_hcnt  = CW'(1);
        end else if (r_lcnt == L_RST1) begin
          w_state = IDLE;
          w_eof   = 1'b1;
        end else w_lcnt = r_lcnt + CW'(1);
    endcase
    if (w_eof) begin
      w_frame_done   = 1'b1;
      w_frame_pixels = r_pcnt;
      w_frame_error  = {r_err[2], r_err[1] | (r_bitcnt != 5'd0), r_err[0]};
      w_busy         = 1'b0;
      w_pcnt         = '0;
      w_bitcnt       = '0;
      w_err          = '0;
    end
  end
  always_ff @(posedge neopixel_clock or negedge neopixel_reset_n)
    if (!neopixel_reset_n) begin
      r_state        <= SYNC;
      r_sync         <= '0;
      r_hcnt         <= '0;
      r_lcnt         <= '0;
      r_bitcnt       <= '0;
      r_pcnt         <= '0;
      r_sreg         <= '0;
      r_err          <= '0;
      r_busy         <= 1'b0;
      r_pixel_valid  <= 1'b0;
      r_pixel_index  <= '0;
      r_pixel_data   <= '0;
      r_frame_done   <= 1'b0;
      r_frame_pixels <= '0;
      r_frame_error  <= '0;
    end else begin
      r_state        <= w_state;
      r_sync         <= {r_sync[1:0], neopixel_in};
      r_hcnt         <= w_hcnt;
      r_lcnt         <= w_lcnt;
      r_bitcnt       <= w_bitcnt;
      r_pcnt         <= w_pcnt;
      r_sreg         <= w_sreg;
      r_err          <= w_err;
      r_busy         <= w_busy;
      r_pixel_valid  <= w_pixel_valid;
      r_pixel_index  <= w_pixel_index;
      r_pixel_data   <= w_pixel_data;
      r_frame_done   <= w_frame_done;
      r_frame_pixels <= w_frame_pixels;
      r_frame_error  <= w_frame_error;
    end
  assign bus.pixel_valid  = r_pixel_valid;
  assign bus.pixel_index  = r_pixel_index;
  assign bus.pixel_data   = r_pixel_data;
  assign bus.frame_done   = r_frame_done;
  assign bus.frame_pixels = r_frame_pixels;
  assign bus.frame_error  = r_frame_error;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_neopixel_decoder.sv
// tb_neopixel_decoder: directed scenarios for neopixel_decoder at default timing
// (T_BIT=75, T_MIN=18, T_RST=6250); fast bits are 80/8 (one) and 20/8 (zero) cycles.
module tb_neopixel_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  int tests = 0;
  int fails = 0;
  int n_fd = 0;
  logic [8:0] fd_pixels = '0;
  logic [2:0] fd_error = '0;
  logic [7:0] q_idx[$];
  logic [23:0] q_dat[$];
  neopixel_decoder_if bus();
  neopixel_decoder dut (
    .neopixel_clock(clk),
    .neopixel_reset_n(rst_n),
    .neopixel_in(din),
    .bus(bus)
  );
  always #4 clk = ~clk;
  always @(negedge clk) begin
    if (bus.pixel_valid) begin
      q_idx.push_back(bus.pixel_index);
      q_dat.push_back(bus.pixel_data);
    end
    if (bus.frame_done) begin
      n_fd      <= n_fd + 1;
      fd_pixels <= bus.frame_pixels;
      fd_error  <= bus.frame_error;
    end
  end
  task automatic pulse(input int h, input int l);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    repeat (l) @(negedge clk);
  endtask
  task automatic send_bit(input logic b, input logic slow);
    if (slow) pulse(b ? 100 : 50, b ? 56 : 106);
    else pulse(b ? 80 : 20, 8);
  endtask
  task automatic send_word(input logic [23:0] w, input int n, input logic slow);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i], slow);
  endtask
  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic clear_q();
    q_idx.delete();
    q_dat.delete();
  endtask
  task automatic test_reset();
    int n0;
    rst_n = 1'b0;
    din = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({bus.pixel_valid, bus.frame_done, bus.busy} !== 3'b000) begin fails++; $display("FAIL reset_strobes: got %b want 000", {bus.pixel_valid, bus.frame_done, bus.busy}); end
    tests++; if ({bus.pixel_index, bus.pixel_data, bus.frame_pixels, bus.frame_error} !== 44'd0) begin fails++; $display("FAIL reset_data: got %h want 0", {bus.pixel_index, bus.pixel_data, bus.frame_pixels, bus.frame_error}); end
    rst_n = 1'b1;
    clear_q();
    n0 = n_fd;
    send_word(24'hFFFFFF, 24, 1'b0);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL presync_busy: got %b want 0", bus.busy); end
    gap(6300);
    tests++; if (q_idx.size() != 0) begin fails++; $display("FAIL presync_strobes: got %0d want 0", q_idx.size()); end
    tests++; if (n_fd != n0) begin fails++; $display("FAIL presync_frame_done: got %0d want 0", n_fd - n0); end
  endtask
  task automatic test_single_pixel();
    int n0;
    clear_q();
    n0 = n_fd;
    send_word(24'hA53CF0, 24, 1'b1);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy_mid: got %b want 1", bus.busy); end
    gap(7000);
    tests++; if (n_fd != n0 + 1) begin fails++; $display("FAIL single_frame_done: got %0d want 1", n_fd - n0); end
    tests++; if (q_idx.size() != 1) begin fails++; $display("FAIL single_count: got %0d want 1", q_idx.size()); end
    tests++; if ((q_idx.size() > 0 ? q_idx[0] : 8'hxx) !== 8'd0) begin fails++; $display("FAIL single_index: got %h want 00", q_idx.size() > 0 ? q_idx[0] : 8'hxx); end
    tests++; if ((q_dat.size() > 0 ? q_dat[0] : 24'hxxxxxx) !== 24'hA53CF0) begin fails++; $display("FAIL single_data: got %h want a53cf0", q_dat.size() > 0 ? q_dat[0] : 24'hxxxxxx); end
    tests++; if (fd_pixels !== 9'd1) begin fails++; $display("FAIL single_frame_pixels: got %0d want 1", fd_pixels); end
    tests++; if (fd_error !== 3'b000) begin fails++; $display("FAIL single_frame_error: got %b want 000", fd_error); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
    tests++; if (bus.pixel_data !== 24'hA53CF0) begin fails++; $display("FAIL single_data_hold: got %h want a53cf0", bus.pixel_data); end
  endtask
  task automatic test_full_frame();
    clear_q();
    for (int i = 0; i < 12; i++) send_word(24'(i * 24'h010101), 24, 1'b0);
    gap(6300);
    tests++; if (q_idx.size() != 12) begin fails++; $display("FAIL full_count: got %0d want 12", q_idx.size()); end
    for (int i = 0; i < q_idx.size(); i++) begin
      tests++; if (q_idx[i] !== 8'(i)) begin fails++; $display("FAIL full_index[%0d]: got %0d want %0d", i, q_idx[i], i); end
      tests++; if (q_dat[i] !== 24'(i * 24'h010101)) begin fails++; $display("FAIL full_data[%0d]: got %h want %h", i, q_dat[i], 24'(i * 24'h010101)); end
    end
    tests++; if (fd_pixels !== 9'd12) begin fails++; $display("FAIL full_frame_pixels: got %0d want 12", fd_pixels); end
    tests++; if (fd_error !== 3'b000) begin fails++; $display("FAIL full_frame_error: got %b want 000", fd_error); end
  endtask
  task automatic test_overflow();
    clear_q();
    for (int i = 0; i < 14; i++) send_word(24'h000000, 24, 1'b0);
    gap(6300);
    tests++; if (q_idx.size() != 12) begin fails++; $display("FAIL ovf_count: got %0d want 12", q_idx.size()); end
    tests++; if ((q_idx.size() > 0 ? q_idx[0] : 8'hxx) !== 8'd0) begin fails++; $display("FAIL ovf_first_index: got %h want 00", q_idx.size() > 0 ? q_idx[0] : 8'hxx); end
    tests++; if ((q_idx.size() > 0 ? q_idx[q_idx.size() - 1] : 8'hxx) !== 8'd11) begin fails++; $display("FAIL ovf_last_index: got %h want 0b", q_idx.size() > 0 ? q_idx[q_idx.size() - 1] : 8'hxx); end
    tests++; if (fd_pixels !== 9'd14) begin fails++; $display("FAIL ovf_frame_pixels: got %0d want 14", fd_pixels); end
    tests++; if (fd_error !== 3'b100) begin fails++; $display("FAIL ovf_frame_error: got %b want 100", fd_error); end
  endtask
  task automatic test_threshold();
    int n0;
    clear_q();
    n0 = n_fd;
    pulse(74, 8);
    pulse(75, 8);
    pulse(18, 8);
    pulse(17, 8);
    gap(6300);
    tests++; if (n_fd != n0 + 1) begin fails++; $display("FAIL thr_frame_done: got %0d want 1", n_fd - n0); end
    tests++; if (q_idx.size() != 0) begin fails++; $display("FAIL thr_strobes: got %0d want 0", q_idx.size()); end
    tests++; if (fd_pixels !== 9'd0) begin fails++; $display("FAIL thr_frame_pixels: got %0d want 0", fd_pixels); end
    tests++; if (fd_error !== 3'b011) begin fails++; $display("FAIL thr_frame_error: got %b want 011", fd_error); end
  endtask
  task automatic test_partial();
    clear_q();
    send_word(24'h123456, 24, 1'b0);
    send_word(24'hFC0000, 6, 1'b0);
    gap(6300);
    tests++; if (q_idx.size() != 1) begin fails++; $display("FAIL part_count: got %0d want 1", q_idx.size()); end
    tests++; if ((q_dat.size() > 0 ? q_dat[0] : 24'hxxxxxx) !== 24'h123456) begin fails++; $display("FAIL part_data: got %h want 123456", q_dat.size() > 0 ? q_dat[0] : 24'hxxxxxx); end
    tests++; if (fd_pixels !== 9'd1) begin fails++; $display("FAIL part_frame_pixels: got %0d want 1", fd_pixels); end
    tests++; if (fd_error !== 3'b010) begin fails++; $display("FAIL part_frame_error: got %b want 010", fd_error); end
  endtask
  task automatic test_reset_mid();
    int n0;
    clear_q();
    send_word(24'hFFFF00, 10, 1'b0);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rmid_busy_before: got %b want 1", bus.busy); end
    din = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if ({bus.pixel_valid, bus.frame_done, bus.busy} !== 3'b000) begin fails++; $display("FAIL rmid_strobes: got %b want 000", {bus.pixel_valid, bus.frame_done, bus.busy}); end
    tests++; if ({bus.pixel_index, bus.pixel_data, bus.frame_pixels, bus.frame_error} !== 44'd0) begin fails++; $display("FAIL rmid_data: got %h want 0", {bus.pixel_index, bus.pixel_data, bus.frame_pixels, bus.frame_error}); end
    din = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n0 = n_fd;
    send_word(24'h5A5A5A, 24, 1'b0);
    gap(2000);
    tests++; if (q_idx.size() != 0) begin fails++; $display("FAIL rmid_resync_strobes: got %0d want 0", q_idx.size()); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rmid_resync_busy: got %b want 0", bus.busy); end
    tests++; if (n_fd != n0) begin fails++; $display("FAIL rmid_resync_frame_done: got %0d want 0", n_fd - n0); end
  endtask
  initial begin
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_overflow();
    test_threshold();
    test_partial();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
